seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_div_step.sv | 28 ++
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared types and helpers for the sequential divider.
//   state_e   - FSM encoding (IDLE, RUN, ZERO, DONE), 2 bits
//   cnt_width - iteration counter width able to hold the value DATAWIDTH
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division iteration (combinational).
//   prem      in  partial remainder
//   qmsb      in  next dividend bit shifted into the remainder
//   divisor   in  divisor
//   next_prem out updated partial remainder
//   qbit      out quotient bit produced by this iteration
module div_step #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] prem,
  input  logic                 qmsb,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic [DATAWIDTH-1:0] next_prem,
  output logic                 qbit
);

  logic [DATAWIDTH:0] trial;

  // One bit wider than the operands so the MSB is a clean borrow.
  assign trial = {prem, qmsb} - {1'b0, divisor};
  assign qbit  = ~trial[DATAWIDTH];

  // On borrow the shifted remainder is below the divisor, so its low bits
  // hold the whole value; on no borrow the difference is below the divisor.
  assign next_prem = trial[DATAWIDTH] ? {prem[DATAWIDTH-2:0], qmsb}
                                      : trial[DATAWIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit/cycle.
//   Clk       in  rising-edge clock
//   Rst_n     in  synchronous active-low reset
//   start     in  request, accepted when not busy (IDLE or DONE cycle)
//   dividend  in  numerator, captured with accepted start
//   divisor   in  denominator, captured with accepted start
//   busy      out division in progress
//   done      out one-cycle pulse when results update
//   quotient  out result, held until the next done
//   remainder out result, held until the next done
//   dbz       out last result was a divide by zero
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0] remainder,
  output logic                 dbz
);

  localparam int CW = cnt_width(DATAWIDTH);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATAWIDTH-1:0]  prem_q, qreg_q, dvs_q;
  logic [DATAWIDTH-1:0]  quot_q, rem_q;
  logic                  busy_q, done_q, dbz_q;

  logic [DATAWIDTH-1:0]  step_prem;
  logic                  step_qbit;

  div_step #(.DATAWIDTH(DATAWIDTH)) u_step (
    .prem      (prem_q),
    .qmsb      (qreg_q[DATAWIDTH-1]),
    .divisor   (dvs_q),
    .next_prem (step_prem),
    .qbit      (step_qbit)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      qreg_q  <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a start just like IDLE for back-to-back operation.
        IDLE, DONE: begin
          if (start) begin
            qreg_q  <= dividend;  // dividend bits feed the remainder MSB-first
            dvs_q   <= divisor;
            prem_q  <= '0;
            cnt_q   <= CW'(DATAWIDTH);
            busy_q  <= 1'b1;
            state_q <= (divisor == '0) ? ZERO : RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            prem_q <= step_prem;
            qreg_q <= {qreg_q[DATAWIDTH-2:0], step_qbit};
            cnt_q  <= cnt_q - CW'(1);
          end else begin
            // All bits produced; publish on the following edge.
            quot_q  <= qreg_q;
            rem_q   <= prem_q;
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        ZERO: begin
          // qreg_q still holds the untouched dividend here.
          quot_q  <= '1;
          rem_q   <= qreg_q;
          dbz_q   <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks on an 8-bit divider plus a randomized
// sweep on a 32-bit divider, using immediate assertions.
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8;
  logic [7:0]  dvd8, dvs8, q8, r8;
  logic        busy8, done8, dbz8;

  logic        start32;
  logic [31:0] dvd32, dvs32, q32, r32;
  logic        busy32, done32, dbz32;

  seq_divider #(.DATAWIDTH(8)) dut8 (
    .Clk(clk), .Rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .dbz(dbz8)
  );

  seq_divider #(.DATAWIDTH(32)) dut32 (
    .Clk(clk), .Rst_n(rst_n), .start(start32), .dividend(dvd32), .divisor(dvs32),
    .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .dbz(dbz32)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capture edge t0.
  task automatic go8(input logic [7:0] n, input logic [7:0] d);
    start8 = 1'b1; dvd8 = n; dvs8 = d;
    @(negedge clk);
    start8 = 1'b0; dvd8 = 8'hA5; dvs8 = 8'h5A;  // later operand changes must not matter
  endtask

  // From the negedge after t0, count edges until done (bounded).
  task automatic wait8(output int lat);
    lat = 0;
    while (!done8 && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic chk_res8(input string tag, input int lat, input int elat,
                          input logic [7:0] eq, input logic [7:0] er, input logic edbz);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_q"},   32'(q8), 32'(eq));
    chk({tag, "_r"},   32'(r8), 32'(er));
    chk({tag, "_dbz"}, 32'(dbz8), 32'(edbz));
  endtask

  initial begin
    int lat, pulses, first;
    logic [7:0] cq, cr;
    logic [31:0] n, d;

    rst_n = 1'b0; start8 = 1'b0; dvd8 = '0; dvs8 = '0;
    start32 = 1'b0; dvd32 = '0; dvs32 = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_q",    32'(q8), 0);
    chk("rst_r",    32'(r8), 0);
    chk("rst_dbz",  32'(dbz8), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100/7: busy through t0..t0+8, done only at t0+9
    go8(8'd100, 8'd7);
    for (int k = 0; k <= 8; k++) begin
      chk($sformatf("b1_busy%0d", k), 32'(busy8), 1);
      chk($sformatf("b1_done%0d", k), 32'(done8), 0);
      if (k == 4) chk("b1_q_midrun", 32'(q8), 0);
      @(negedge clk);
    end
    chk("b1_done", 32'(done8), 1);
    chk("b1_busy_end", 32'(busy8), 0);
    chk_res8("b1", 9, 9, 8'd14, 8'd2, 1'b0);
    @(negedge clk);
    chk("b1_done_pulse", 32'(done8), 0);
    chk("b1_q_hold", 32'(q8), 14);

    // 255/1 then 5/9 issued in the done cycle
    go8(8'd255, 8'd1);
    wait8(lat);
    chk_res8("b2a", lat, 9, 8'd255, 8'd0, 1'b0);
    go8(8'd5, 8'd9);
    chk("b2b_accept_busy", 32'(busy8), 1);
    chk("b2b_q_held", 32'(q8), 255);
    wait8(lat);
    chk_res8("b2b", lat, 9, 8'd0, 8'd5, 1'b0);

    // 37/0 then 20/4
    @(negedge clk);
    go8(8'd37, 8'd0);
    wait8(lat);
    chk_res8("z", lat, 1, 8'd255, 8'd37, 1'b1);
    @(negedge clk);
    go8(8'd20, 8'd4);
    chk("z2_dbz_held", 32'(dbz8), 1);
    wait8(lat);
    chk_res8("z2", lat, 9, 8'd5, 8'd0, 1'b0);

    // 200/3 with a stray start at t0+3
    @(negedge clk);
    go8(8'd200, 8'd3);
    pulses = 0; first = -1; cq = '0; cr = '0;
    for (int k = 0; k < 20; k++) begin
      if (done8) begin
        pulses++;
        if (first < 0) begin first = k; cq = q8; cr = r8; end
      end
      if (k == 2) begin start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd5; end
      if (k == 3) start8 = 1'b0;
      @(negedge clk);
    end
    chk("ign_pulses", 32'(pulses), 1);
    chk("ign_lat", 32'(first), 9);
    chk("ign_q", 32'(cq), 66);
    chk("ign_r", 32'(cr), 2);

    // Reset at t0+4 during 200/3, with start held high to show reset wins
    go8(8'd200, 8'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start8 = 1'b1; dvd8 = 8'd9; dvs8 = 8'd2;
    @(negedge clk);
    chk("ab_busy", 32'(busy8), 0);
    chk("ab_done", 32'(done8), 0);
    chk("ab_q",    32'(q8), 0);
    chk("ab_r",    32'(r8), 0);
    chk("ab_dbz",  32'(dbz8), 0);
    rst_n = 1'b1; start8 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      if (done8 || busy8) pulses++;
      @(negedge clk);
    end
    chk("ab_no_activity", 32'(pulses), 0);

    // 32-bit sweep, back-to-back, with corner operand values mixed in
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0: n = 32'd0;
        1: n = 32'd1;
        2: n = 32'hFFFF_FFFF;
        default: n = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: d = 32'd0;
        1: d = 32'd1;
        2: d = 32'hFFFF_FFFF;
        3: d = 32'($urandom_range(2, 255));
        default: d = $urandom;
      endcase
      start32 = 1'b1; dvd32 = n; dvs32 = d;
      @(negedge clk);
      start32 = 1'b0; dvd32 = $urandom; dvs32 = $urandom;
      lat = 0;
      while (!done32 && lat < 100) begin @(negedge clk); lat++; end
      if (d == 0) begin
        chk("r32_lat", 32'(lat), 1);
        chk("r32_q",   q32, 32'hFFFF_FFFF);
        chk("r32_r",   r32, n);
        chk("r32_dbz", 32'(dbz32), 1);
      end else begin
        chk("r32_lat", 32'(lat), 33);
        chk("r32_q",   q32, n / d);
        chk("r32_r",   r32, n % d);
        chk("r32_dbz", 32'(dbz32), 0);
        chk("r32_ident", 32'(((64'(q32) * 64'(d)) + 64'(r32) == 64'(n)) && (r32 < d)), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
